johnson_decoder_checker: RTL and testbench
==========================================

Name: johnson_decoder_checker

Overview:
- Receive side for the 4-bit Johnson counter.
- Samples a 4-bit Johnson-coded count bus and decodes it to a 3-bit binary index.
- Flags illegal codes and out-of-sequence steps, tracks lock to a valid counting stream with a small FSM, and keeps a saturating error count.
- Sits downstream of any Johnson/shift counter (local or across a board link) as a decoder and health monitor.

Parameters:
- LOCK_COUNT, 4: consecutive good transitions required to enter LOCKED (legal range 1..15).
- ALLOW_HOLD, 1: 1 = repeating the same legal code is a good transition; 0 = a repeat is a sequence error.
- ERR_W, 8: width of err_count.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- code_in  input  4  Johnson-coded count from the counter.
- code_valid  input  1  code_in is sampled on this cycle.
- index  output  3  decoded binary index of the last legal code.
- index_valid  output  1  one-cycle pulse: index updated from a legal code.
- illegal_code  output  1  one-cycle pulse: sampled code is not a Johnson state.
- seq_error  output  1  one-cycle pulse: legal code is not the successor (or a permitted hold) of the previous code.
- locked  output  1  FSM is in LOCKED.
- err_count  output  ERR_W  saturating count of illegal_code plus seq_error events.

Behaviour:
- Reset (reset == 0 at a rising clk): index = 0, index_valid = 0, illegal_code = 0, seq_error = 0, locked = 0, err_count = 0, have_prev = 0, good counter = 0, FSM = UNLOCKED. Reset overrides every other input on that edge. A reset mid-stream discards history; the next legal sample is treated as the first.
- Decode table, code -> index:
  - 0x0 -> 0, 0x1 -> 1, 0x3 -> 2, 0x7 -> 3
  - 0xF -> 4, 0xE -> 5, 0xC -> 6, 0x8 -> 7
- Illegal codes: 0x2, 0x4, 0x5, 0x6, 0x9, 0xA, 0xB, 0xD.
- All outputs are registered. Latency is 1 cycle: a sample on edge N appears on outputs after edge N.
- When code_valid = 0: pulses deassert; index, locked, err_count and have_prev hold.
- When code_valid = 1 and the code is illegal:
  - illegal_code = 1, index_valid = 0, index holds.
  - have_prev = 0, good counter = 0, FSM -> UNLOCKED, err_count += 1.
- When code_valid = 1 and the code is legal:
  - index <= decoded value, index_valid = 1.
  - If have_prev = 0: no sequence check; have_prev = 1; good counter unchanged.
  - If have_prev = 1 and decoded == (prev + 1) mod 8: good transition. Wrap 7 -> 0 (0x8 -> 0x0) is legal.
  - If have_prev = 1 and decoded == prev: good transition if ALLOW_HOLD = 1, otherwise sequence error.
  - Any other value: sequence error. seq_error = 1, err_count += 1, good counter = 0, FSM -> UNLOCKED, have_prev stays 1. The new index becomes the reference for the next check.
- Good counter: increments on each good transition and saturates at LOCK_COUNT.
- FSM states and transitions:
  - UNLOCKED -> LOCKED on the edge where the good counter reaches LOCK_COUNT; locked rises the same cycle.
  - LOCKED -> UNLOCKED on any illegal code or sequence error.
  - No other transitions.
- err_count saturates at 2^ERR_W - 1 and never wraps. illegal_code and seq_error are mutually exclusive in a cycle, so the increment is at most 1.

Test Plan:
- Reset, then a full cycle 0x0,0x1,0x3,0x7,0xF,0xE,0xC,0x8,0x0 with code_valid = 1 every cycle -> index 0,1,2,3,4,5,6,7,0 one cycle later; locked rises after the 4th good transition (5th sample); err_count = 0.
- Drive each illegal code 0x2,0x4,0x5,0x6,0x9,0xA,0xB,0xD once -> illegal_code pulses 8 times; index holds its last value; err_count = 8; locked = 0.
- Run locked at index 3 (0x7), then drive 0xC -> seq_error = 1, index = 6, locked drops next cycle, err_count + 1; continuing 0x8,0x0,0x1,0x3 relocks after the 4th good transition.
- ALLOW_HOLD = 0, stream 0x1,0x1 -> seq_error on the second sample. ALLOW_HOLD = 1, same stream -> no error and the good counter increments.
- ERR_W = 3, drive 10 illegal codes -> err_count stops at 7; toggle code_valid low between samples -> no pulses on the idle cycles.
- Assert reset low while locked with err_count = 5 -> all outputs return to 0 on the next edge; the first legal sample after release raises no seq_error.

Source files
------------

// File: rtl/johnson_decoder_checker_if.sv
// Bus between a Johnson count source and johnson_decoder_checker.
// The master drives the sampled code; the slave returns the decoded index and health flags.
interface johnson_decoder_checker_if #(
  parameter int ERR_W = 8
);
  logic [3:0]       code_in;
  logic             code_valid;
  logic [2:0]       index;
  logic             index_valid;
  logic             illegal_code;
  logic             seq_error;
  logic             locked;
  logic [ERR_W-1:0] err_count;

  modport master (
    output code_in, code_valid,
    input  index, index_valid, illegal_code, seq_error, locked, err_count
  );

  modport slave (
    input  code_in, code_valid,
    output index, index_valid, illegal_code, seq_error, locked, err_count
  );
endinterface

// File: rtl/johnson_decoder_checker.sv
// Decodes a 4-bit Johnson count to a binary index, flags illegal and out-of-sequence codes,
// tracks lock to a clean counting stream and keeps a saturating error count.
//
// state       | meaning
// ST_UNLOCKED | fewer than LOCK_COUNT consecutive good transitions since the last error
// ST_LOCKED   | stream is counting cleanly; left on any illegal code or sequence error
module johnson_decoder_checker #(
  parameter int LOCK_COUNT = 4,
  parameter bit ALLOW_HOLD = 1'b1,
  parameter int ERR_W      = 8
) (
  input logic                      i_clk,
  input logic                      i_reset,
  johnson_decoder_checker_if.slave bus
);

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_t;

  localparam logic [3:0]       LC      = 4'(LOCK_COUNT);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_t           r_state, w_state_nxt;
  logic [2:0]       r_index, w_index_nxt;
  logic             r_index_valid, w_index_valid_nxt;
  logic             r_illegal, w_illegal_nxt;
  logic             r_seq_err, w_seq_err_nxt;
  logic             r_have_prev, w_have_prev_nxt;
  logic [3:0]       r_good, w_good_nxt;
  logic [ERR_W-1:0] r_err, w_err_nxt;

  logic             w_legal;
  logic [2:0]       w_dec;
  logic [2:0]       w_succ;
  logic             w_err_inc;
  logic             w_good_step;

  always_comb begin
    w_legal = 1'b1;
    w_dec   = 3'd0;
    case (bus.code_in)
      4'h0:    w_dec = 3'd0;
      4'h1:    w_dec = 3'd1;
      4'h3:    w_dec = 3'd2;
      4'h7:    w_dec = 3'd3;
      4'hF:    w_dec = 3'd4;
      4'hE:    w_dec = 3'd5;
      4'hC:    w_dec = 3'd6;
      4'h8:    w_dec = 3'd7;
      default: w_legal = 1'b0;
    endcase
  end

  // The last legal index doubles as the reference for the sequence check; wraps 7 -> 0.
  assign w_succ = r_index + 3'd1;

  always_comb begin
    w_state_nxt       = r_state;
    w_index_nxt       = r_index;
    w_index_valid_nxt = 1'b0;
    w_illegal_nxt     = 1'b0;
    w_seq_err_nxt     = 1'b0;
    w_have_prev_nxt   = r_have_prev;
    w_good_nxt        = r_good;
    w_err_inc         = 1'b0;
    w_good_step       = 1'b0;

    if (bus.code_valid) begin
      if (!w_legal) begin
        w_illegal_nxt   = 1'b1;
        w_have_prev_nxt = 1'b0;
        w_good_nxt      = 4'd0;
        w_state_nxt     = ST_UNLOCKED;
        w_err_inc       = 1'b1;
      end else begin
        w_index_nxt       = w_dec;
        w_index_valid_nxt = 1'b1;
        w_have_prev_nxt   = 1'b1;
        if (r_have_prev) begin
          if ((w_dec == w_succ) || (ALLOW_HOLD && (w_dec == r_index))) begin
            w_good_step = 1'b1;
            if (r_good != LC) w_good_nxt = r_good + 4'd1;
          end else begin
            w_seq_err_nxt = 1'b1;
            w_good_nxt    = 4'd0;
            w_state_nxt   = ST_UNLOCKED;
            w_err_inc     = 1'b1;
          end
        end
      end
    end

    if (w_good_step && (w_good_nxt == LC)) w_state_nxt = ST_LOCKED;

    w_err_nxt = (w_err_inc && (r_err != ERR_MAX)) ? r_err + 1'b1 : r_err;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) r_state <= ST_UNLOCKED;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_index       <= 3'd0;
      r_index_valid <= 1'b0;
      r_illegal     <= 1'b0;
      r_seq_err     <= 1'b0;
      r_have_prev   <= 1'b0;
      r_good        <= 4'd0;
      r_err         <= '0;
    end else begin
      r_index       <= w_index_nxt;
      r_index_valid <= w_index_valid_nxt;
      r_illegal     <= w_illegal_nxt;
      r_seq_err     <= w_seq_err_nxt;
      r_have_prev   <= w_have_prev_nxt;
      r_good        <= w_good_nxt;
      r_err         <= w_err_nxt;
    end
  end

  assign bus.index        = r_index;
  assign bus.index_valid  = r_index_valid;
  assign bus.illegal_code = r_illegal;
  assign bus.seq_error    = r_seq_err;
  assign bus.locked       = (r_state == ST_LOCKED);
  assign bus.err_count    = r_err;

endmodule

// File: tb/tb_johnson_decoder_checker.sv
// Directed bench for johnson_decoder_checker: default build, a no-hold build and a 3-bit
// error counter build, each on its own bus and reset.
module tb_johnson_decoder_checker;

  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  johnson_decoder_checker_if #(.ERR_W(8)) ifa ();
  johnson_decoder_checker_if #(.ERR_W(8)) ifb ();
  johnson_decoder_checker_if #(.ERR_W(3)) ifc ();

  johnson_decoder_checker #(.LOCK_COUNT(4), .ALLOW_HOLD(1'b1), .ERR_W(8)) dut_a (
    .i_clk(clk), .i_reset(rst_a), .bus(ifa));
  johnson_decoder_checker #(.LOCK_COUNT(4), .ALLOW_HOLD(1'b0), .ERR_W(8)) dut_b (
    .i_clk(clk), .i_reset(rst_b), .bus(ifb));
  johnson_decoder_checker #(.LOCK_COUNT(4), .ALLOW_HOLD(1'b1), .ERR_W(3)) dut_c (
    .i_clk(clk), .i_reset(rst_c), .bus(ifc));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  logic [3:0] full_seq [9] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};
  int         full_idx [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
  logic [3:0] bad_seq  [8] = '{4'h2, 4'h4, 4'h5, 4'h6, 4'h9, 4'hA, 4'hB, 4'hD};
  logic [3:0] pre_seq  [6] = '{4'hC, 4'h8, 4'h0, 4'h1, 4'h3, 4'h7};
  logic [3:0] rel_seq  [4] = '{4'h8, 4'h0, 4'h1, 4'h3};
  logic [3:0] lock_seq [5] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF};

  initial begin
    ifa.code_in = 4'h0; ifa.code_valid = 1'b0;
    ifb.code_in = 4'h0; ifb.code_valid = 1'b0;
    ifc.code_in = 4'h0; ifc.code_valid = 1'b0;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    tick();
    tick();
    chk("rst_index",   16'(ifa.index), 16'd0);
    chk("rst_iv",      16'(ifa.index_valid), 16'd0);
    chk("rst_illegal", 16'(ifa.illegal_code), 16'd0);
    chk("rst_seq",     16'(ifa.seq_error), 16'd0);
    chk("rst_locked",  16'(ifa.locked), 16'd0);
    chk("rst_err",     16'(ifa.err_count), 16'd0);
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    tick();

    // Full Johnson cycle: lock after 4th good transition (5th sample)
    ifa.code_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      ifa.code_in = full_seq[i];
      tick();
      chk("cyc_index",  16'(ifa.index), 16'(full_idx[i]));
      chk("cyc_iv",     16'(ifa.index_valid), 16'd1);
      chk("cyc_seq",    16'(ifa.seq_error), 16'd0);
      chk("cyc_locked", 16'(ifa.locked), (i >= 4) ? 16'd1 : 16'd0);
    end
    chk("cyc_err", 16'(ifa.err_count), 16'd0);

    // All eight illegal codes
    for (int i = 0; i < 8; i++) begin
      ifa.code_in = bad_seq[i];
      tick();
      chk("ill_flag",   16'(ifa.illegal_code), 16'd1);
      chk("ill_iv",     16'(ifa.index_valid), 16'd0);
      chk("ill_index",  16'(ifa.index), 16'd0);
      chk("ill_locked", 16'(ifa.locked), 16'd0);
      chk("ill_err",    16'(ifa.err_count), 16'(i + 1));
    end

    // Lock at index 3, then jump to 0xC
    for (int i = 0; i < 6; i++) begin
      ifa.code_in = pre_seq[i];
      tick();
    end
    chk("pre_locked", 16'(ifa.locked), 16'd1);
    chk("pre_index",  16'(ifa.index), 16'd3);
    ifa.code_in = 4'hC;
    tick();
    chk("jmp_seq",    16'(ifa.seq_error), 16'd1);
    chk("jmp_index",  16'(ifa.index), 16'd6);
    chk("jmp_locked", 16'(ifa.locked), 16'd0);
    chk("jmp_err",    16'(ifa.err_count), 16'd9);
    for (int i = 0; i < 4; i++) begin
      ifa.code_in = rel_seq[i];
      tick();
      chk("rel_seq",    16'(ifa.seq_error), 16'd0);
      chk("rel_locked", 16'(ifa.locked), (i == 3) ? 16'd1 : 16'd0);
    end

    // Hold permitted: repeat keeps lock, and repeats alone can build lock
    ifa.code_in = 4'h3;
    tick();
    chk("hold_seq",    16'(ifa.seq_error), 16'd0);
    chk("hold_locked", 16'(ifa.locked), 16'd1);
    ifa.code_in = 4'h5;
    tick();
    chk("hold_ill_err", 16'(ifa.err_count), 16'd10);
    for (int i = 0; i < 5; i++) begin
      ifa.code_in = 4'h1;
      tick();
      chk("hold_rep_seq",    16'(ifa.seq_error), 16'd0);
      chk("hold_rep_locked", 16'(ifa.locked), (i == 4) ? 16'd1 : 16'd0);
    end
    ifa.code_valid = 1'b0;
    tick();
    chk("idle_iv",     16'(ifa.index_valid), 16'd0);
    chk("idle_locked", 16'(ifa.locked), 16'd1);
    chk("idle_index",  16'(ifa.index), 16'd1);

    // No-hold build: repeat is a sequence error
    ifb.code_valid = 1'b1;
    ifb.code_in = 4'h1;
    tick();
    chk("nh_first_seq", 16'(ifb.seq_error), 16'd0);
    tick();
    chk("nh_rep_seq",   16'(ifb.seq_error), 16'd1);
    chk("nh_rep_index", 16'(ifb.index), 16'd1);
    chk("nh_rep_err",   16'(ifb.err_count), 16'd1);
    for (int i = 0; i < 4; i++) begin
      ifb.code_in = bad_seq[i];
      tick();
    end
    chk("nh_err5", 16'(ifb.err_count), 16'd5);
    for (int i = 0; i < 5; i++) begin
      ifb.code_in = lock_seq[i];
      tick();
    end
    chk("nh_locked", 16'(ifb.locked), 16'd1);
    chk("nh_err",    16'(ifb.err_count), 16'd5);

    // Reset while locked, with an illegal code presented on the reset edge
    ifb.code_in = 4'hD;
    rst_b = 1'b0;
    tick();
    chk("mrst_index",   16'(ifb.index), 16'd0);
    chk("mrst_iv",      16'(ifb.index_valid), 16'd0);
    chk("mrst_illegal", 16'(ifb.illegal_code), 16'd0);
    chk("mrst_seq",     16'(ifb.seq_error), 16'd0);
    chk("mrst_locked",  16'(ifb.locked), 16'd0);
    chk("mrst_err",     16'(ifb.err_count), 16'd0);
    rst_b = 1'b1;
    ifb.code_in = 4'h7;
    tick();
    chk("post_seq",   16'(ifb.seq_error), 16'd0);
    chk("post_index", 16'(ifb.index), 16'd3);
    chk("post_iv",    16'(ifb.index_valid), 16'd1);
    ifb.code_valid = 1'b0;

    // 3-bit error counter saturates at 7; idle cycles carry no pulses
    for (int k = 1; k <= 10; k++) begin
      ifc.code_valid = 1'b1;
      ifc.code_in = bad_seq[(k - 1) % 8];
      tick();
      chk("sat_ill", 16'(ifc.illegal_code), 16'd1);
      chk("sat_err", 16'(ifc.err_count), (k > 7) ? 16'd7 : 16'(k));
      ifc.code_valid = 1'b0;
      tick();
      chk("sat_idle_ill", 16'(ifc.illegal_code), 16'd0);
      chk("sat_idle_iv",  16'(ifc.index_valid), 16'd0);
      chk("sat_idle_err", 16'(ifc.err_count), (k > 7) ? 16'd7 : 16'(k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
